nim_game_core: RTL and testbench
================================

Name: nim_game_core

Overview:
- Parametrised Game-of-Nim rules engine for two players. It holds the heap counts, enforces turn legality, detects game over and keeps saturating per-player scores.
- It generalises the fixed 4-row board to N_ROWS heaps and adds selectable normal/misère rules.
- It feeds the LED-matrix renderer (heap counts), the stepper driver (turn_done pulse) and the 7-segment scoreboard (scores), and it takes debounced single-cycle button pulses from the top level.

Parameters:
- N_ROWS, 4, number of heaps (2..8).
- MAX_STONES, 7, maximum stones per heap (1..15). Heap count width CW = clog2(MAX_STONES+1).
- MISERE, 0, 0 = last mover wins; 1 = last mover loses.
- SCORE_W, 4, score counter width; scores saturate at 2^SCORE_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sel_valid  in  1  pulse: select heap sel_row for this turn
- sel_row  in  clog2(N_ROWS)  heap index
- take  in  1  pulse: remove one stone from the locked heap
- end_turn  in  1  pulse: commit the turn and pass play to the other player
- newgame  in  1  pulse: restore heaps, keep scores
- heaps  out  N_ROWS*CW  heap i count at bits [i*CW +: CW]
- active_row  out  clog2(N_ROWS)  locked heap index
- row_locked  out  1  a heap is locked this turn
- player  out  1  player to move (0/1)
- turn_done  out  1  one-cycle pulse on each accepted end_turn (stepper advance)
- game_over  out  1  game finished
- winner  out  1  valid while game_over
- score_p0  out  SCORE_W  games won by player 0
- score_p1  out  SCORE_W  games won by player 1
- err  out  1  one-cycle pulse on each rejected action

Behaviour:
- Single clock. reset is synchronous and active-high.
- Reset values:
  - heaps[i] = min(2i+1, MAX_STONES)
  - state SELECT
  - player = 0, active_row = 0, row_locked = 0
  - turn_done = 0, err = 0
  - game_over = 0, winner = 0
  - score_p0 = 0, score_p1 = 0
- Reset mid-game aborts everything, scores included.
- Internal taken counter: 0..MAX_STONES. It is cleared on entering SELECT.
- Input priority within a cycle: newgame > end_turn > sel_valid > take. Only the highest-priority asserted input acts; the lower ones are silently dropped and do not set err.
- State SELECT (no heap locked):
  - sel_valid with sel_row < N_ROWS and heaps[sel_row] != 0: set active_row = sel_row and row_locked = 1; go to TAKING next cycle.
  - sel_valid that fails either check: err.
  - take: err.
  - end_turn: err (a move must remove at least one stone).
- State TAKING:
  - take with heaps[active_row] > 0: decrement the heap and increment taken. Outputs update the following cycle.
  - take on an empty locked heap: err.
  - sel_valid to a different row: err. sel_valid to the same row: no-op.
  - end_turn with taken >= 1: pulse turn_done for 1 cycle and clear row_locked.
    - If all heaps are now 0: go to OVER. winner = player XOR MISERE. Increment the winner's score, saturating at 2^SCORE_W-1. player does not toggle.
    - Otherwise: toggle player and go to SELECT.
  - Emptying the last stone does not end the game by itself; end_turn must still be pressed.
- State OVER:
  - game_over = 1.
  - take, sel_valid and end_turn each raise err.
- newgame, from any state:
  - Next cycle: heaps restored to reset values, go to SELECT, row_locked = 0, game_over = 0.
  - Scores are kept.
  - player = loser of the previous game if it ended in OVER; otherwise player is unchanged.
- Outputs are registered. A pulse input is accepted on the cycle it is high and is visible on the outputs 1 cycle later.
- err and turn_done are never both high in the same cycle.

Decomposition:
- Package nim_pkg:
  - state enum {SELECT, TAKING, OVER}
  - function init_count(i, max) returning min(2i+1, max)
  - function clog2 helper
- One natural sub-module: nim_score_counter (saturating SCORE_W-bit counter with inc and clr), instanced twice.
- The heap array and the FSM stay in nim_game_core.

Test Plan (N_ROWS=4, MAX_STONES=7, MISERE=0, SCORE_W=4 unless stated):
- Reset then idle → heaps = 1,3,5,7; player 0; game_over 0; both scores 0.
- sel row 3, take ×3, end_turn → heap3 = 4; turn_done pulses exactly once; player = 1; row_locked = 0.
- end_turn in SELECT; sel row 1 then sel row 2; take in OVER → each gives one err pulse and no state change.
- Empty all heaps by alternating legal turns, player 1 makes the last end_turn → game_over = 1, winner = 1, score_p1 = 1. Repeat with MISERE=1 → winner = 0, score_p0 = 1.
- Player 1 wins 16 consecutive games with newgame between them → score_p1 saturates at 15; after each newgame player = 0 (the loser) and heaps return to 1,3,5,7.
- newgame and take asserted in the same cycle mid-turn → heaps restored, no decrement, no err. reset in TAKING → all reset values, scores 0.

Source files
------------

// File: rtl/nim_pkg.sv
// Shared types and elaboration helpers for the Nim rules engine.
// Pure declarations: no logic, no latency, no flow control.
package nim_pkg;

  typedef enum logic [1:0] {
    SELECT = 2'd0,
    TAKING = 2'd1,
    OVER   = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Starting heap i holds 2i+1 stones, capped at the per-heap maximum.
  function automatic int init_count(input int i, input int max);
    return (2 * i + 1 < max) ? 2 * i + 1 : max;
  endfunction

endpackage

// File: rtl/nim_score_counter.sv
// Saturating win counter; inc/clr act on the next clock edge, no backpressure.
// Holds at all-ones instead of wrapping so the scoreboard never rolls over.
module nim_score_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nim_game_core.sv
// Two-player Nim rules engine: heaps, turn legality, game over and scores.
// Every accepted pulse shows on the registered outputs one cycle later; no backpressure, illegal actions pulse err.
module nim_game_core
  import nim_pkg::*;
#(
  parameter  int N_ROWS     = 4,
  parameter  int MAX_STONES = 7,
  parameter  int MISERE     = 0,
  parameter  int SCORE_W    = 4,
  localparam int RW         = clog2(N_ROWS),
  localparam int CW         = clog2(MAX_STONES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel_valid,
  input  logic [RW-1:0]        sel_row,
  input  logic                 take,
  input  logic                 end_turn,
  input  logic                 newgame,
  output logic [N_ROWS*CW-1:0] heaps,
  output logic [RW-1:0]        active_row,
  output logic                 row_locked,
  output logic                 player,
  output logic                 turn_done,
  output logic                 game_over,
  output logic                 winner,
  output logic [SCORE_W-1:0]   score_p0,
  output logic [SCORE_W-1:0]   score_p1,
  output logic                 err
);

  state_t        state;
  logic [CW-1:0] heap_q [N_ROWS];
  logic [CW-1:0] taken;
  logic          all_zero;
  logic          row_ok;
  logic          win_next;
  logic          game_won;

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < N_ROWS; i++) begin
      if (heap_q[i] != '0) all_zero = 1'b0;
    end
  end

  assign row_ok   = int'(sel_row) < N_ROWS;
  assign win_next = player ^ 1'(MISERE);
  assign game_won = !newgame && (state == TAKING) && end_turn && (taken != '0) && all_zero;

  for (genvar g = 0; g < N_ROWS; g++) begin : g_heaps
    assign heaps[g*CW +: CW] = heap_q[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ROWS; i++) heap_q[i] <= CW'(init_count(i, MAX_STONES));
      state      <= SELECT;
      taken      <= '0;
      player     <= 1'b0;
      active_row <= '0;
      row_locked <= 1'b0;
      turn_done  <= 1'b0;
      err        <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      turn_done <= 1'b0;
      err       <= 1'b0;
      if (newgame) begin
        for (int i = 0; i < N_ROWS; i++) heap_q[i] <= CW'(init_count(i, MAX_STONES));
        state      <= SELECT;
        taken      <= '0;
        row_locked <= 1'b0;
        game_over  <= 1'b0;
        // The loser of a finished game opens the next one.
        if (state == OVER) player <= ~winner;
      end else begin
        case (state)
          SELECT: begin
            if (end_turn) begin
              err <= 1'b1;
            end else if (sel_valid) begin
              if (row_ok && (heap_q[sel_row] != '0)) begin
                active_row <= sel_row;
                row_locked <= 1'b1;
                state      <= TAKING;
              end else begin
                err <= 1'b1;
              end
            end else if (take) begin
              err <= 1'b1;
            end
          end
          TAKING: begin
            if (end_turn) begin
              if (taken != '0) begin
                turn_done  <= 1'b1;
                row_locked <= 1'b0;
                taken      <= '0;
                if (all_zero) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                  winner    <= win_next;
                end else begin
                  player <= ~player;
                  state  <= SELECT;
                end
              end else begin
                err <= 1'b1;
              end
            end else if (sel_valid) begin
              if (sel_row != active_row) err <= 1'b1;
            end else if (take) begin
              if (heap_q[active_row] != '0) begin
                heap_q[active_row] <= heap_q[active_row] - 1'b1;
                taken              <= taken + 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          OVER: begin
            if (end_turn || sel_valid || take) err <= 1'b1;
          end
          default: state <= SELECT;
        endcase
      end
    end
  end

  nim_score_counter #(.W(SCORE_W)) u_score_p0 (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (game_won && !win_next),
    .count(score_p0)
  );

  nim_score_counter #(.W(SCORE_W)) u_score_p1 (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .inc  (game_won && win_next),
    .count(score_p1)
  );

endmodule

// File: tb/tb_nim_game_core.sv
// Scoreboard bench for nim_game_core: a normal-rules and a misere instance share one stimulus stream.
// Stimulus pushes hand-derived expected outputs tagged with a due cycle; a monitor pops and compares.
module tb_nim_game_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel_valid = 1'b0;
  logic [1:0]  sel_row = 2'd0;
  logic        take = 1'b0;
  logic        end_turn = 1'b0;
  logic        newgame = 1'b0;

  logic [11:0] heaps, m_heaps;
  logic [1:0]  active_row, m_active_row;
  logic        row_locked, m_row_locked;
  logic        player, m_player;
  logic        turn_done, m_turn_done;
  logic        game_over, m_game_over;
  logic        winner, m_winner;
  logic [3:0]  score_p0, score_p1, m_score_p0, m_score_p1;
  logic        err, m_err;

  nim_game_core #(.N_ROWS(4), .MAX_STONES(7), .MISERE(0), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .sel_valid(sel_valid), .sel_row(sel_row), .take(take),
    .end_turn(end_turn), .newgame(newgame), .heaps(heaps), .active_row(active_row),
    .row_locked(row_locked), .player(player), .turn_done(turn_done), .game_over(game_over),
    .winner(winner), .score_p0(score_p0), .score_p1(score_p1), .err(err)
  );

  nim_game_core #(.N_ROWS(4), .MAX_STONES(7), .MISERE(1), .SCORE_W(4)) dut_m (
    .clk(clk), .reset(reset), .sel_valid(sel_valid), .sel_row(sel_row), .take(take),
    .end_turn(end_turn), .newgame(newgame), .heaps(m_heaps), .active_row(m_active_row),
    .row_locked(m_row_locked), .player(m_player), .turn_done(m_turn_done), .game_over(m_game_over),
    .winner(m_winner), .score_p0(m_score_p0), .score_p1(m_score_p1), .err(m_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          due;
    string       label;
    logic [11:0] heaps;
    logic        player, locked, td, err, over, win;
    logic [1:0]  arow;
    logic [3:0]  s0, s1;
    logic        mplayer, mwin;
    logic [3:0]  ms0, ms1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_ok;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Expected architectural state, maintained by hand alongside the stimulus.
  int h[4];
  bit pl, mpl, lk, ov, wn, mwn;
  int ar, s0, s1, ms0, ms1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      mon_ok = (heaps == mon_e.heaps) && (m_heaps == mon_e.heaps)
            && (player == mon_e.player) && (m_player == mon_e.mplayer)
            && (row_locked == mon_e.locked) && (m_row_locked == mon_e.locked)
            && (!mon_e.locked || (active_row == mon_e.arow && m_active_row == mon_e.arow))
            && (turn_done == mon_e.td) && (m_turn_done == mon_e.td)
            && (err == mon_e.err) && (m_err == mon_e.err)
            && (game_over == mon_e.over) && (m_game_over == mon_e.over)
            && (!mon_e.over || (winner == mon_e.win && m_winner == mon_e.mwin))
            && (score_p0 == mon_e.s0) && (score_p1 == mon_e.s1)
            && (m_score_p0 == mon_e.ms0) && (m_score_p1 == mon_e.ms1);
      if (!mon_ok) begin
        errors++;
        $display("FAIL %s: got heaps=%h/%h p=%0d mp=%0d lk=%0d ar=%0d td=%0d err=%0d go=%0d w=%0d mw=%0d s=%0d/%0d ms=%0d/%0d; want heaps=%h p=%0d mp=%0d lk=%0d ar=%0d td=%0d err=%0d go=%0d w=%0d mw=%0d s=%0d/%0d ms=%0d/%0d",
                 mon_e.label, heaps, m_heaps, player, m_player, row_locked, active_row, turn_done, err,
                 game_over, winner, m_winner, score_p0, score_p1, m_score_p0, m_score_p1,
                 mon_e.heaps, mon_e.player, mon_e.mplayer, mon_e.locked, mon_e.arow, mon_e.td, mon_e.err,
                 mon_e.over, mon_e.win, mon_e.mwin, mon_e.s0, mon_e.s1, mon_e.ms0, mon_e.ms1);
      end
    end
  end

  task automatic act(input bit sv, input int row, input bit tk, input bit et, input bit ng,
                     input bit etd, input bit eerr, input string lbl);
    exp_t e;
    @(negedge clk);
    sel_valid = sv;
    sel_row   = row[1:0];
    take      = tk;
    end_turn  = et;
    newgame   = ng;
    e.due     = cyc + 1;
    e.label   = lbl;
    e.heaps   = {h[3][2:0], h[2][2:0], h[1][2:0], h[0][2:0]};
    e.player  = pl;
    e.locked  = lk;
    e.arow    = ar[1:0];
    e.td      = etd;
    e.err     = eerr;
    e.over    = ov;
    e.win     = wn;
    e.s0      = s0[3:0];
    e.s1      = s1[3:0];
    e.mplayer = mpl;
    e.mwin    = mwn;
    e.ms0     = ms0[3:0];
    e.ms1     = ms1[3:0];
    exp_q.push_back(e);
  endtask

  task automatic idle(input string lbl);
    act(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lbl);
  endtask

  task automatic restore_heaps();
    h[0] = 1; h[1] = 3; h[2] = 5; h[3] = 7;
  endtask

  task automatic reset_model();
    restore_heaps();
    pl = 0; mpl = 0; lk = 0; ov = 0; wn = 0; mwn = 0;
    ar = 0; s0 = 0; s1 = 0; ms0 = 0; ms1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sel_valid = 1'b0; take = 1'b0; end_turn = 1'b0; newgame = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    reset_model();
  endtask

  task automatic do_newgame(input string lbl);
    restore_heaps();
    if (ov) begin
      pl  = ~wn;
      mpl = ~mwn;
    end
    ov = 0;
    lk = 0;
    act(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, lbl);
  endtask

  // Closing a turn: either the board is empty and the game ends, or play passes.
  task automatic close_turn(input string lbl);
    lk = 0;
    if (h[0] == 0 && h[1] == 0 && h[2] == 0 && h[3] == 0) begin
      ov  = 1;
      wn  = pl;
      mwn = ~mpl;
      if (wn) begin if (s1 < 15) s1++; end else begin if (s0 < 15) s0++; end
      if (mwn) begin if (ms1 < 15) ms1++; end else begin if (ms0 < 15) ms0++; end
    end else begin
      pl  = ~pl;
      mpl = ~mpl;
    end
    act(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, lbl);
  endtask

  task automatic turn(input int r, input int n, input string lbl);
    lk = 1;
    ar = r;
    act(1'b1, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {lbl, " sel"});
    for (int k = 0; k < n; k++) begin
      h[r]--;
      act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {lbl, " take"});
    end
    close_turn({lbl, " end"});
  endtask

  initial begin
    reset_model();
    do_reset();
    idle("reset idle");

    turn(3, 3, "t1");
    idle("t1 settle");

    act(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "end_turn in select");
    act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "take in select");
    lk = 1; ar = 1;
    act(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sel row1");
    act(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sel row2 while locked");
    act(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sel same row");
    h[1]--;
    act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t2 take");
    close_turn("t2 end");

    turn(0, 1, "g1 r0");
    act(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sel empty row");
    turn(1, 2, "g1 r1");
    lk = 1; ar = 2;
    act(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "g1 r2 sel");
    for (int k = 0; k < 5; k++) begin
      h[2]--;
      act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "g1 r2 take");
    end
    act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "take on empty locked heap");
    close_turn("g1 r2 end");
    turn(3, 4, "g1 final");
    idle("game over idle");
    act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "take in over");
    act(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "sel in over");
    act(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "end_turn in over");

    for (int g = 0; g < 15; g++) begin
      do_newgame("newgame after over");
      turn(0, 1, "sat r0");
      turn(1, 3, "sat r1");
      turn(2, 5, "sat r2");
      turn(3, 7, "sat r3");
    end
    idle("score saturated");

    do_newgame("newgame before mid-turn");
    lk = 1; ar = 2;
    act(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid sel");
    h[2]--;
    act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid take");
    restore_heaps();
    lk = 0;
    act(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "newgame beats take");
    idle("after newgame+take");

    lk = 1; ar = 1;
    act(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "pre-reset sel");
    h[1]--;
    act(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "pre-reset take");
    do_reset();
    idle("reset in taking");
    idle("reset settle");

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
